// File: rtl/sort_step_engine.sv
// sort_step_engine: bubble-sort engine with free-running, paused and
// single-step operation, early exit after a swap-free pass, and optional
// step-back. Each step does one compare/swap of the pair (j, j+1) in pass i.
// Exports the array plus the compare and pass pointers for the bar renderer.
//
// Optional feature: define SORT_UNDO_EN to build the undo history stack and
// enable step_back. Without it, no history storage exists and step_back is
// ignored in every state.
module sort_step_engine #(
    parameter int N = 5,
    parameter int W = 7,
    parameter int DELAY = 100_000_000,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [N*W-1:0]   data_in,
    input  logic             start,
    input  logic             pause_toggle,
    input  logic             step_fwd,
    input  logic             step_back,
    output logic [N*W-1:0]   data_out,
    output logic [IDX_W-1:0] cmp_idx,
    output logic [IDX_W-1:0] pass_idx,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic             last_swap,
    output logic [15:0]      step_count
);

    localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DELAY - 1);
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(N - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      arr_q [N];
    logic [W-1:0]      arr_d [N];
    logic [IDX_W-1:0]  i_q, i_d;
    logic [IDX_W-1:0]  j_q, j_d;
    logic [15:0]       sc_q, sc_d;
    logic              last_swap_q, last_swap_d;
    logic              pass_sw_q, pass_sw_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              paused_q, paused_d;
    logic              done_q, done_d;

    logic              do_step;
    logic              do_undo;
    logic              swap_now;
    logic              pass_sw_after;
    logic [IDX_W-1:0]  j_next;
    logic [IDX_W-1:0]  j_last;
    logic              undo_ok;

`ifdef SORT_UNDO_EN
    localparam int MAXS = N * (N - 1) / 2;
    localparam int SP_W = $clog2(MAXS + 1);

    // Each entry is {swapped, pass_swapped_before} for one executed step.
    logic [1:0]        hist_q [MAXS];
    logic [1:0]        hist_d [MAXS];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [1:0]        undo_entry;
    logic              undo_prev_swap;
    logic [IDX_W-1:0]  undo_i;
    logic [IDX_W-1:0]  undo_j;

    // Locate the step being undone: in DONE the pointers never advanced past
    // the final pair, otherwise it is the pair before (i, j).
    always_comb begin
        undo_ok        = step_back && (sp_q != '0);
        undo_entry     = hist_q[sp_q - SP_W'(1)];
        undo_prev_swap = (sp_q >= SP_W'(2)) ? hist_q[sp_q - SP_W'(2)][1] : 1'b0;
        if (state_q == S_DONE) begin
            undo_i = i_q;
            undo_j = j_q;
        end else if (j_q != '0) begin
            undo_i = i_q;
            undo_j = j_q - IDX_W'(1);
        end else begin
            undo_i = i_q - IDX_W'(1);
            undo_j = IDX_W'(N - 1) - i_q;
        end
    end
`else
    logic unused_step_back;
    assign unused_step_back = step_back;
    assign undo_ok = 1'b0;
`endif

    // Compare the current pair and work out where the pointers go next.
    always_comb begin
        swap_now      = arr_q[j_q] > arr_q[j_next];
        pass_sw_after = pass_sw_q | swap_now;
        j_next        = j_q + IDX_W'(1);
        j_last        = LAST_PASS - i_q;
    end

    // Command decode by priority, then apply a forward step or an undo.
    always_comb begin
        state_d     = state_q;
        arr_d       = arr_q;
        i_d         = i_q;
        j_d         = j_q;
        sc_d        = sc_q;
        last_swap_d = last_swap_q;
        pass_sw_d   = pass_sw_q;
        cnt_d       = cnt_q;
        do_step     = 1'b0;
        do_undo     = 1'b0;
`ifdef SORT_UNDO_EN
        hist_d      = hist_q;
        sp_d        = sp_q;
`endif

        if (load) begin
            for (int k = 0; k < N; k++) begin
                arr_d[k] = data_in[k*W +: W];
            end
            i_d         = '0;
            j_d         = '0;
            sc_d        = '0;
            last_swap_d = 1'b0;
            pass_sw_d   = 1'b0;
            cnt_d       = '0;
            state_d     = S_IDLE;
`ifdef SORT_UNDO_EN
            sp_d        = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end
                end
                S_RUN: begin
                    if (pause_toggle) begin
                        state_d = S_PAUSE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        do_step = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (pause_toggle) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else if (undo_ok) begin
                        do_undo = 1'b1;
                    end else if (step_fwd) begin
                        do_step = 1'b1;
                    end
                end
                S_DONE: begin
                    if (undo_ok) begin
                        do_undo = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (do_step) begin
            if (swap_now) begin
                arr_d[j_q]    = arr_q[j_next];
                arr_d[j_next] = arr_q[j_q];
            end
            last_swap_d = swap_now;
            pass_sw_d   = pass_sw_after;
            sc_d        = (sc_q != 16'hFFFF) ? sc_q + 16'd1 : sc_q;
`ifdef SORT_UNDO_EN
            if (int'(sp_q) < MAXS) begin
                hist_d[sp_q] = {swap_now, pass_sw_q};
                sp_d         = sp_q + SP_W'(1);
            end
`endif
            if (j_q < j_last) begin
                j_d = j_next;
            end else if (!pass_sw_after || (i_q == LAST_PASS)) begin
                state_d = S_DONE;
            end else begin
                i_d       = i_q + IDX_W'(1);
                j_d       = '0;
                pass_sw_d = 1'b0;
            end
        end

`ifdef SORT_UNDO_EN
        if (do_undo) begin
            i_d = undo_i;
            j_d = undo_j;
            if (undo_entry[1]) begin
                arr_d[undo_j]               = arr_q[undo_j + IDX_W'(1)];
                arr_d[undo_j + IDX_W'(1)]   = arr_q[undo_j];
            end
            pass_sw_d   = undo_entry[0];
            sc_d        = sc_q - 16'd1;
            last_swap_d = undo_prev_swap;
            sp_d        = sp_q - SP_W'(1);
            state_d     = S_PAUSE;
        end
`endif

        busy_d   = (state_d == S_RUN) || (state_d == S_PAUSE);
        paused_d = (state_d == S_PAUSE);
        done_d   = (state_d == S_DONE);
    end

    // State, array, pointers and status flags; reset wins over every command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            for (int k = 0; k < N; k++) begin
                arr_q[k] <= '0;
            end
            i_q         <= '0;
            j_q         <= '0;
            sc_q        <= '0;
            last_swap_q <= 1'b0;
            pass_sw_q   <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            paused_q    <= 1'b0;
            done_q      <= 1'b0;
`ifdef SORT_UNDO_EN
            sp_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            arr_q       <= arr_d;
            i_q         <= i_d;
            j_q         <= j_d;
            sc_q        <= sc_d;
            last_swap_q <= last_swap_d;
            pass_sw_q   <= pass_sw_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            paused_q    <= paused_d;
            done_q      <= done_d;
`ifdef SORT_UNDO_EN
            sp_q        <= sp_d;
`endif
        end
    end

`ifdef SORT_UNDO_EN
    // History contents need no reset: an empty stack pointer hides them.
    always_ff @(posedge clk) begin
        hist_q <= hist_d;
    end
`endif

    // Repack the element array onto the flat output bus.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            data_out[k*W +: W] = arr_q[k];
        end
    end

    assign cmp_idx    = j_q;
    assign pass_idx   = i_q;
    assign busy       = busy_q;
    assign paused     = paused_q;
    assign done       = done_q;
    assign last_swap  = last_swap_q;
    assign step_count = sc_q;

endmodule

// File: tb/tb_sort_step_engine.sv
// tb_sort_step_engine: directed bench for sort_step_engine with N=5, W=7,
// DELAY=4. Expected arrays, pointers and step counts are worked out by hand
// from the bubble-sort rules. Undo scenarios build only with SORT_UNDO_EN.
module tb_sort_step_engine;

    localparam int N = 5;
    localparam int W = 7;
    localparam int DELAY = 4;
    localparam int IDX_W = $clog2(N);

    localparam logic [4:0] C_LOAD  = 5'b10000;
    localparam logic [4:0] C_PAUSE = 5'b01000;
    localparam logic [4:0] C_BACK  = 5'b00100;
    localparam logic [4:0] C_FWD   = 5'b00010;
    localparam logic [4:0] C_START = 5'b00001;

    logic             clk;
    logic             reset;
    logic             load;
    logic [N*W-1:0]   data_in;
    logic             start;
    logic             pause_toggle;
    logic             step_fwd;
    logic             step_back;
    logic [N*W-1:0]   data_out;
    logic [IDX_W-1:0] cmp_idx;
    logic [IDX_W-1:0] pass_idx;
    logic             busy;
    logic             paused;
    logic             done;
    logic             last_swap;
    logic [15:0]      step_count;

    int checks = 0;
    int errors = 0;
    int base_sc;
    int exp_cmp;
    int exp_pass;
    logic [N*W-1:0] exp_arr;

    sort_step_engine #(.N(N), .W(W), .DELAY(DELAY)) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .data_in      (data_in),
        .start        (start),
        .pause_toggle (pause_toggle),
        .step_fwd     (step_fwd),
        .step_back    (step_back),
        .data_out     (data_out),
        .cmp_idx      (cmp_idx),
        .pass_idx     (pass_idx),
        .busy         (busy),
        .paused       (paused),
        .done         (done),
        .last_swap    (last_swap),
        .step_count   (step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Element 0 sits in the low bits, matching the data_in packing.
    function automatic logic [N*W-1:0] pack(input int a0, a1, a2, a3, a4);
        return {W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    // Advance one edge and sample 1 time unit later, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the selected command pulses for exactly one clock edge.
    task automatic applyStimulus(input logic [4:0] cmds);
        load         = cmds[4];
        pause_toggle = cmds[3];
        step_back    = cmds[2];
        step_fwd     = cmds[1];
        start        = cmds[0];
        tick();
        load         = 1'b0;
        pause_toggle = 1'b0;
        step_back    = 1'b0;
        step_fwd     = 1'b0;
        start        = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset        = 1'b1;
        load         = 1'b0;
        data_in      = '0;
        start        = 1'b0;
        pause_toggle = 1'b0;
        step_fwd     = 1'b0;
        step_back    = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset values
        checkOutput("rst_data",      64'(data_out),   64'd0);
        checkOutput("rst_cmp",       64'(cmp_idx),    64'd0);
        checkOutput("rst_pass",      64'(pass_idx),   64'd0);
        checkOutput("rst_busy",      64'(busy),       64'd0);
        checkOutput("rst_paused",    64'(paused),     64'd0);
        checkOutput("rst_done",      64'(done),       64'd0);
        checkOutput("rst_last_swap", 64'(last_swap),  64'd0);
        checkOutput("rst_step_cnt",  64'(step_count), 64'd0);

        // Reverse-sorted input runs to completion in 10 timed steps
        $display("[TB] reverse array, free run");
        data_in = pack(50, 40, 30, 20, 10);
        applyStimulus(C_LOAD);
        checkOutput("rev_load_data", 64'(data_out), 64'(pack(50, 40, 30, 20, 10)));
        checkOutput("rev_load_busy", 64'(busy), 64'd0);
        applyStimulus(C_START);
        checkOutput("rev_start_busy", 64'(busy), 64'd1);
        checkOutput("rev_start_sc",   64'(step_count), 64'd0);
        repeat (3) tick();
        checkOutput("rev_no_early_step", 64'(step_count), 64'd0);
        tick();
        checkOutput("rev_first_step_sc",   64'(step_count), 64'd1);
        checkOutput("rev_first_step_cmp",  64'(cmp_idx), 64'd1);
        checkOutput("rev_first_step_swap", 64'(last_swap), 64'd1);
        checkOutput("rev_first_step_data", 64'(data_out), 64'(pack(40, 50, 30, 20, 10)));
        repeat (35) tick();
        checkOutput("rev_sc_before_done", 64'(step_count), 64'd9);
        checkOutput("rev_not_done_yet",   64'(done), 64'd0);
        tick();
        checkOutput("rev_done",      64'(done), 64'd1);
        checkOutput("rev_done_sc",   64'(step_count), 64'd10);
        checkOutput("rev_done_data", 64'(data_out), 64'(pack(10, 20, 30, 40, 50)));
        checkOutput("rev_done_busy", 64'(busy), 64'd0);
        checkOutput("rev_done_pass", 64'(pass_idx), 64'd3);
        checkOutput("rev_done_cmp",  64'(cmp_idx), 64'd0);
        applyStimulus(C_START);
        checkOutput("done_ignores_start", 64'(done), 64'd1);
        checkOutput("done_ignores_start_sc", 64'(step_count), 64'd10);

        // Already-sorted input exits after one swap-free pass
        $display("[TB] sorted array, early exit");
        data_in = pack(10, 20, 30, 40, 50);
        applyStimulus(C_LOAD);
        checkOutput("srt_load_sc",   64'(step_count), 64'd0);
        checkOutput("srt_load_done", 64'(done), 64'd0);
        applyStimulus(C_START);
        repeat (15) tick();
        checkOutput("srt_sc_before_done", 64'(step_count), 64'd3);
        checkOutput("srt_not_done_yet",   64'(done), 64'd0);
        tick();
        checkOutput("srt_done",      64'(done), 64'd1);
        checkOutput("srt_done_sc",   64'(step_count), 64'd4);
        checkOutput("srt_done_pass", 64'(pass_idx), 64'd0);
        checkOutput("srt_done_cmp",  64'(cmp_idx), 64'd3);
        checkOutput("srt_done_swap", 64'(last_swap), 64'd0);
        checkOutput("srt_done_data", 64'(data_out), 64'(pack(10, 20, 30, 40, 50)));

        // Pause before the first step, then single-step three times
        $display("[TB] pause and single step");
        data_in = pack(50, 40, 30, 20, 10);
        applyStimulus(C_LOAD);
        applyStimulus(C_START);
        tick();
        applyStimulus(C_PAUSE);
        checkOutput("pse_paused", 64'(paused), 64'd1);
        checkOutput("pse_busy",   64'(busy), 64'd1);
        repeat (6) tick();
        checkOutput("pse_holds_sc", 64'(step_count), 64'd0);
        applyStimulus(C_FWD);
        applyStimulus(C_FWD);
        applyStimulus(C_FWD);
        checkOutput("pse_step3_data", 64'(data_out), 64'(pack(40, 30, 20, 50, 10)));
        checkOutput("pse_step3_cmp",  64'(cmp_idx), 64'd3);
        checkOutput("pse_step3_sc",   64'(step_count), 64'd3);
        checkOutput("pse_step3_swap", 64'(last_swap), 64'd1);

`ifdef SORT_UNDO_EN
        $display("[TB] step back");
        applyStimulus(C_BACK);
        checkOutput("undo1_data", 64'(data_out), 64'(pack(40, 30, 50, 20, 10)));
        checkOutput("undo1_cmp",  64'(cmp_idx), 64'd2);
        checkOutput("undo1_sc",   64'(step_count), 64'd2);
        checkOutput("undo1_swap", 64'(last_swap), 64'd1);
        applyStimulus(C_BACK);
        applyStimulus(C_BACK);
        checkOutput("undo3_data",   64'(data_out), 64'(pack(50, 40, 30, 20, 10)));
        checkOutput("undo3_cmp",    64'(cmp_idx), 64'd0);
        checkOutput("undo3_sc",     64'(step_count), 64'd0);
        checkOutput("undo3_swap",   64'(last_swap), 64'd0);
        checkOutput("undo3_paused", 64'(paused), 64'd1);
        applyStimulus(C_BACK);
        checkOutput("undo_empty_data", 64'(data_out), 64'(pack(50, 40, 30, 20, 10)));
        checkOutput("undo_empty_sc",   64'(step_count), 64'd0);
        checkOutput("undo_empty_cmp",  64'(cmp_idx), 64'd0);
        base_sc  = 0;
        exp_arr  = pack(40, 50, 30, 20, 10);
        exp_cmp  = 1;
        exp_pass = 0;
`else
        $display("[TB] step back without history");
        applyStimulus(C_BACK);
        checkOutput("noundo_data", 64'(data_out), 64'(pack(40, 30, 20, 50, 10)));
        checkOutput("noundo_sc",   64'(step_count), 64'd3);
        checkOutput("noundo_cmp",  64'(cmp_idx), 64'd3);
        base_sc  = 3;
        exp_arr  = pack(40, 30, 20, 10, 50);
        exp_cmp  = 0;
        exp_pass = 1;
`endif

        // Resume from PAUSE: the counter restarts so the next step is DELAY later
        applyStimulus(C_PAUSE);
        checkOutput("resume_paused", 64'(paused), 64'd0);
        checkOutput("resume_busy",   64'(busy), 64'd1);
        repeat (3) tick();
        checkOutput("resume_no_early_step", 64'(step_count), 64'(base_sc));
        tick();
        checkOutput("resume_step_sc",   64'(step_count), 64'(base_sc + 1));
        checkOutput("resume_step_data", 64'(data_out), 64'(exp_arr));
        checkOutput("resume_step_cmp",  64'(cmp_idx), 64'(exp_cmp));
        checkOutput("resume_step_pass", 64'(pass_idx), 64'(exp_pass));

        // Reset while running overrides a simultaneous load
        $display("[TB] reset during run");
        data_in = pack(1, 2, 3, 4, 5);
        reset = 1'b1;
        load  = 1'b1;
        tick();
        reset = 1'b0;
        load  = 1'b0;
        checkOutput("midrst_data",   64'(data_out), 64'd0);
        checkOutput("midrst_busy",   64'(busy), 64'd0);
        checkOutput("midrst_paused", 64'(paused), 64'd0);
        checkOutput("midrst_done",   64'(done), 64'd0);
        checkOutput("midrst_sc",     64'(step_count), 64'd0);
        checkOutput("midrst_cmp",    64'(cmp_idx), 64'd0);
        checkOutput("midrst_pass",   64'(pass_idx), 64'd0);
        checkOutput("midrst_swap",   64'(last_swap), 64'd0);
        repeat (5) tick();
        checkOutput("midrst_stays_idle", 64'(busy), 64'd0);

        // load beats step_fwd in the same cycle while paused
        $display("[TB] load versus step_fwd");
        data_in = pack(50, 40, 30, 20, 10);
        applyStimulus(C_LOAD);
        applyStimulus(C_START);
        applyStimulus(C_PAUSE);
        applyStimulus(C_FWD);
        checkOutput("prio_pre_sc", 64'(step_count), 64'd1);
        data_in = pack(1, 2, 3, 4, 5);
        applyStimulus(C_LOAD | C_FWD);
        checkOutput("prio_data",   64'(data_out), 64'(pack(1, 2, 3, 4, 5)));
        checkOutput("prio_busy",   64'(busy), 64'd0);
        checkOutput("prio_paused", 64'(paused), 64'd0);
        checkOutput("prio_sc",     64'(step_count), 64'd0);
        checkOutput("prio_cmp",    64'(cmp_idx), 64'd0);
        checkOutput("prio_swap",   64'(last_swap), 64'd0);
        applyStimulus(C_FWD);
        checkOutput("idle_ignores_fwd", 64'(step_count), 64'd0);

        // Equal neighbours are never swapped: 4+3+2 steps, not 10
        $display("[TB] equal elements");
        data_in = pack(20, 20, 10, 30, 30);
        applyStimulus(C_LOAD);
        applyStimulus(C_START);
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
        end
        checkOutput("eq_done_within_budget", 64'(done), 64'd1);
        checkOutput("eq_sc",   64'(step_count), 64'd9);
        checkOutput("eq_data", 64'(data_out), 64'(pack(10, 20, 20, 30, 30)));
        checkOutput("eq_pass", 64'(pass_idx), 64'd2);
        checkOutput("eq_cmp",  64'(cmp_idx), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
